tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter SLOTS, default 8, the number of time slots per frame; legal range 2..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  slot strobe; din and sync are sampled only on rising clk edges where en=1.
REQ-005 SHALL have port sync  input  1  frame start; marks slot 0 of a frame.
REQ-006 SHALL have port din  input  1  serial time-multiplexed data; one bit per slot.
REQ-007 SHALL have port dout  output  SLOTS  demultiplexed frame, registered; slot k appears on dout[k].
REQ-008 SHALL have port dout_valid  output  1  one-cycle pulse when dout is updated with a complete frame.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted by an early sync.

Function
REQ-010 SHALL implement the states IDLE and RECV, plus PAR when PARITY_CHECK_EN is defined.
REQ-011 In IDLE with en=1 and sync=1, the block SHALL store din as slot 0, set the slot counter to 1, and enter RECV; in IDLE with sync=0, din SHALL be ignored.
REQ-012 In RECV with en=1 and sync=0, the block SHALL store din into the slot given by the counter and increment the counter.
REQ-013 On the en=1 edge that stores slot SLOTS-1 (macro undefined), the block SHALL load the shift buffer into dout, assert dout_valid at the next clk edge for exactly one cycle, and return to IDLE.
REQ-014 Back-to-back frames: a sync on the first en=1 edge after the last slot SHALL start a new frame with no lost slot.
REQ-015 In RECV, en=1 with sync=1 SHALL abort the partial frame, pulse frame_err for one cycle, leave dout unchanged, and restart at slot 0 using that din bit.
REQ-016 While en=0, the state, the counter, and the partial buffer SHALL hold; dout_valid and frame_err SHALL be 0.
REQ-017 dout SHALL hold its last value between frames; only a completed frame updates it.
REQ-018 The slot counter SHALL be ceil(log2(SLOTS+1)) bits wide and SHALL never exceed SLOTS.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, counter 0, buffer 0, dout 0, dout_valid 0, and frame_err 0.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a sync.

Configuration
REQ-021 With the macro PARITY_CHECK_EN defined:
- each frame carries one extra slot after slot SLOTS-1, holding even parity over the data slots;
- the block SHALL enter PAR after slot SLOTS-1 and sample the parity bit on the next en=1 edge;
- the port parity_err (output, 1 bit) SHALL pulse together with dout_valid when the parity mismatches;
- dout SHALL still update on a mismatch.
REQ-022 With PARITY_CHECK_EN undefined: there SHALL be no PAR state and no parity_err port, and the frame SHALL be exactly SLOTS slots long.
REQ-023 A sync during PAR SHALL be treated as in REQ-015.

Verification
REQ-024 SLOTS=8, en=1 constant, sync at slot 0, din serial 1,0,1,1,0,0,1,0 -> dout=8'b01001101, with dout_valid high for one cycle, one cycle after the last slot.
REQ-025 Two back-to-back frames 8'hA5 then 8'h3C -> two dout_valid pulses 8 cycles apart, with dout=8'hA5 then 8'h3C.
REQ-026 en toggling 1,0,1,0 through a frame of 8'hFF -> dout=8'hFF after 8 en=1 edges; no pulse on any en=0 cycle.
REQ-027 Sync re-asserted at slot 4 -> frame_err pulse, dout keeps its previous value, and the new frame completes 8 en=1 edges later.
REQ-028 rst_n pulsed low at slot 5 -> all outputs 0 asynchronously; no dout_valid until a fresh sync plus 8 slots.
REQ-029 PARITY_CHECK_EN defined, data 8'h01 with parity bit 0 -> dout=8'h01 and parity_err=1; the same data with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/tdm_demux_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_if
//
// Purpose : Bundles the serial TDM input strobes and the demultiplexed frame
//           outputs of tdm_demux into one interface.
//
// Signals : en         - slot strobe; din/sync only count on edges with en=1
//           sync       - frame start, marks slot 0
//           din        - serial data, one bit per slot
//           dout       - last completed frame, slot k on dout[k]
//           dout_valid - one-cycle pulse when dout takes a new frame
//           frame_err  - one-cycle pulse when a partial frame is aborted
//           parity_err - (only with PARITY_CHECK_EN) one-cycle pulse
//                        alongside dout_valid on a parity mismatch
//
// Modports: master - the side feeding the serial stream (testbench, framer)
//           slave  - the demultiplexer itself
//
// Build option: define PARITY_CHECK_EN to add the parity_err signal.
// ---------------------------------------------------------------------------
interface tdm_demux_if #(
    parameter int SLOTS = 8
);
    logic             en;
    logic             sync;
    logic             din;
    logic [SLOTS-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
`ifdef PARITY_CHECK_EN
    logic             parity_err;

    modport master (
        output en, sync, din,
        input  dout, dout_valid, frame_err, parity_err
    );

    modport slave (
        input  en, sync, din,
        output dout, dout_valid, frame_err, parity_err
    );
`else
    modport master (
        output en, sync, din,
        input  dout, dout_valid, frame_err
    );

    modport slave (
        input  en, sync, din,
        output dout, dout_valid, frame_err
    );
`endif
endinterface

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Purpose : Serial time-division demultiplexer. A frame is SLOTS bits long,
//           one bit per en=1 clock edge, with sync marking slot 0. The bits
//           are collected into a buffer and, once the last slot arrives, the
//           whole frame is presented in parallel on dout with a one-cycle
//           dout_valid pulse. A sync arriving mid-frame aborts the partial
//           frame (frame_err pulse, dout untouched) and starts a new one
//           using that same bit as slot 0.
//
// Parameters: SLOTS - slots per frame, legal range 2..16
//
// Ports   : clk   - single clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - tdm_demux_if.slave (en, sync, din in;
//                   dout, dout_valid, frame_err [, parity_err] out)
//
// Build option: PARITY_CHECK_EN
//           When defined, each frame carries one extra slot after slot
//           SLOTS-1 with even parity over the data slots. The FSM gains a
//           PAR state to sample it; parity_err pulses with dout_valid on a
//           mismatch, and dout is updated regardless. When undefined, frames
//           are exactly SLOTS slots and there is no PAR state.
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int SLOTS = 8
) (
    input logic        clk,
    input logic        rst_n,
    tdm_demux_if.slave bus
);

    // Counter spans 0..SLOTS inclusive (SLOTS is parked there in PAR).
    localparam int CNT_W = $clog2(SLOTS + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SLOTS-1:0] frame_buf;
    logic [SLOTS-1:0] frame_buf_nxt;
    logic [SLOTS-1:0] frame_out;
    logic [SLOTS-1:0] frame_out_nxt;
    logic             valid_pulse;
    logic             valid_pulse_nxt;
    logic             err_pulse;
    logic             err_pulse_nxt;
`ifdef PARITY_CHECK_EN
    logic             par_pulse;
    logic             par_pulse_nxt;
`endif

    // Buffer as it would look with din written into the slot the counter
    // points at. A compare loop is used instead of frame_buf[cnt] so the
    // counter (one bit wider than a slot index) never drives a bit select.
    logic [SLOTS-1:0] buf_with_din;
    logic             last_slot;

    always_comb begin
        buf_with_din = frame_buf;
        for (int k = 0; k < SLOTS; k++) begin
            if (cnt == CNT_W'(k)) begin
                buf_with_din[k] = bus.din;
            end
        end
    end

    assign last_slot = (cnt == CNT_W'(SLOTS - 1));

    // Next-state and output logic. Pulses default low so they last exactly
    // one cycle; every edge with en=0 leaves state, counter and buffer alone.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        frame_buf_nxt   = frame_buf;
        frame_out_nxt   = frame_out;
        valid_pulse_nxt = 1'b0;
        err_pulse_nxt   = 1'b0;
`ifdef PARITY_CHECK_EN
        par_pulse_nxt   = 1'b0;
`endif

        if (bus.en) begin
            case (state)
                IDLE: begin
                    // Without sync the bit belongs to no frame and is dropped.
                    if (bus.sync) begin
                        frame_buf_nxt = {{(SLOTS-1){1'b0}}, bus.din};
                        cnt_nxt       = CNT_W'(1);
                        state_nxt     = RECV;
                    end
                end

                RECV: begin
                    if (bus.sync) begin
                        // Early sync: discard the partial frame and treat this
                        // bit as slot 0 of the new one.
                        err_pulse_nxt = 1'b1;
                        frame_buf_nxt = {{(SLOTS-1){1'b0}}, bus.din};
                        cnt_nxt       = CNT_W'(1);
                    end else if (last_slot) begin
                        frame_buf_nxt = buf_with_din;
`ifdef PARITY_CHECK_EN
                        cnt_nxt       = CNT_W'(SLOTS);
                        state_nxt     = PAR;
`else
                        // Publish straight from the merged buffer so the
                        // frame is out one cycle after its last slot.
                        frame_out_nxt   = buf_with_din;
                        valid_pulse_nxt = 1'b1;
                        cnt_nxt         = '0;
                        state_nxt       = IDLE;
`endif
                    end else begin
                        frame_buf_nxt = buf_with_din;
                        cnt_nxt       = cnt + CNT_W'(1);
                    end
                end

`ifdef PARITY_CHECK_EN
                PAR: begin
                    if (bus.sync) begin
                        err_pulse_nxt = 1'b1;
                        frame_buf_nxt = {{(SLOTS-1){1'b0}}, bus.din};
                        cnt_nxt       = CNT_W'(1);
                        state_nxt     = RECV;
                    end else begin
                        // Even parity: the parity bit must equal the XOR of
                        // the data slots. The frame is published either way.
                        frame_out_nxt   = frame_buf;
                        valid_pulse_nxt = 1'b1;
                        par_pulse_nxt   = bus.din ^ (^frame_buf);
                        cnt_nxt         = '0;
                        state_nxt       = IDLE;
                    end
                end
`endif

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_buf   <= '0;
            frame_out   <= '0;
            valid_pulse <= 1'b0;
            err_pulse   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_pulse   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            frame_buf   <= frame_buf_nxt;
            frame_out   <= frame_out_nxt;
            valid_pulse <= valid_pulse_nxt;
            err_pulse   <= err_pulse_nxt;
`ifdef PARITY_CHECK_EN
            par_pulse   <= par_pulse_nxt;
`endif
        end
    end

    assign bus.dout       = frame_out;
    assign bus.dout_valid = valid_pulse;
    assign bus.frame_err  = err_pulse;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = par_pulse;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//
// Purpose : Directed testbench for tdm_demux (SLOTS=8). Stimulus tasks drive
//           the serial stream and push the expected output events (frame
//           completions and aborts, with their data and cycle) into a queue;
//           an independent monitor pops and compares whenever the DUT pulses
//           dout_valid or frame_err. Reset behaviour is checked directly.
//
// Build option: PARITY_CHECK_EN adds the parity slot and parity_err checks.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int SLOTS = 8;

    typedef struct {
        logic             kind;   // 1 = dout_valid, 0 = frame_err
        logic [SLOTS-1:0] data;
        logic             perr;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [SLOTS-1:0] last_dout = '0;
`ifdef PARITY_CHECK_EN
    logic bad_par = 1'b0;
`endif

    tdm_demux_if #(.SLOTS(SLOTS)) bus ();

    tdm_demux #(.SLOTS(SLOTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one slot; returns #1 after the edge that sampled it.
    task automatic step(input logic e, input logic s, input logic d);
        bus.en   = e;
        bus.sync = s;
        bus.din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push_event(input logic kind, input logic [SLOTS-1:0] data, input logic perr);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.perr = perr;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Send one full frame. gaps inserts an en=0 cycle (with sync=1 and an
    // inverted bit, both of which must be ignored) after every slot. abort
    // marks that the sync on slot 0 lands in the middle of another frame.
    task automatic send_frame(input logic [SLOTS-1:0] data, input bit gaps, input bit abort);
        for (int i = 0; i < SLOTS; i++) begin
            step(1'b1, (i == 0), data[i]);
            if (abort && i == 0) push_event(1'b0, last_dout, 1'b0);
`ifndef PARITY_CHECK_EN
            if (i == SLOTS - 1) begin
                push_event(1'b1, data, 1'b0);
                last_dout = data;
            end
`endif
            if (gaps) step(1'b0, 1'b1, ~data[i]);
        end
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b0, (^data) ^ bad_par);
        push_event(1'b1, data, bad_par);
        last_dout = data;
`endif
    endtask

    task automatic check_event(input logic kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk(kind ? "unexpected_dout_valid" : "unexpected_frame_err", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", {31'd0, kind}, {31'd0, e.kind});
            chk(kind ? "dout_on_valid" : "dout_held_on_err", {24'd0, bus.dout}, {24'd0, e.data});
            chk("event_cycle", cyc, e.cyc);
`ifdef PARITY_CHECK_EN
            if (kind) chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
`endif
        end
    endtask

    // Monitor: independent of stimulus, acts only on DUT pulses.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.dout_valid === 1'b1) check_event(1'b1);
            if (bus.frame_err === 1'b1) check_event(1'b0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("reset_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame: serial 1,0,1,1,0,0,1,0 -> 8'b01001101.
        send_frame(8'b0100_1101, 1'b0, 1'b0);

        // Back-to-back frames.
        send_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);

        // Bits without sync while idle are ignored.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);

        // en toggling through a frame.
        send_frame(8'hFF, 1'b1, 1'b0);

        // Abort at slot 4, then a complete new frame.
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
        // Parity: wrong parity bit, then correct parity bit.
        bad_par = 1'b1;
        send_frame(8'h01, 1'b0, 1'b0);
        bad_par = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0);
`endif

        // Asynchronous reset at slot 5 of a frame.
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("async_reset_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("async_reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        last_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        // The rest of the discarded frame must produce nothing.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b0);

        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("all_expected_events_seen", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
